// File: rtl/mult_iter_nxw.sv
// Iterative WIDTH x WIDTH multiplier that adds one WIDTH x CHUNK partial product per cycle; result after N=WIDTH/CHUNK cycles (or fewer with EARLY_EXIT).
// Single outstanding request: in_ready only in IDLE, product held in DONE until out_ready; flush aborts from any state.
module mult_iter_nxw #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  logic               accept, finish, a_neg, b_neg;
  logic [CHUNK-1:0]   chunk;
  logic [2*WIDTH-1:0] pp, sum;
  logic [WIDTH-1:0]   upper;

  assign accept = (state == IDLE) && in_valid && !flush;
  assign a_neg  = a_signed & a[WIDTH-1];
  assign b_neg  = b_signed & b[WIDTH-1];

  always_comb begin
    chunk  = mag_b[CHUNK*count +: CHUNK];
    pp     = ({{WIDTH{1'b0}}, mag_a} * {{(2*WIDTH-CHUNK){1'b0}}, chunk}) << (CHUNK*count);
    sum    = acc + pp;
    // Chunks of |b| not yet consumed after this cycle; zero means nothing left to add.
    upper  = mag_b >> (CHUNK * (32'(count) + 1));
    finish = (count == CW'(N-1)) || ((EARLY_EXIT != 0) && (upper == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else if (flush) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      // Most-negative operand negates to 2^(WIDTH-1), which still fits as an unsigned magnitude.
      mag_a <= a_neg ? (~a + 1'b1) : a;
      mag_b <= b_neg ? (~b + 1'b1) : b;
      neg   <= a_neg ^ b_neg;
      acc   <= '0;
      count <= '0;
    end else if (state == CALC) begin
      acc   <= sum;
      count <= count + 1'b1;
      if (finish) product <= neg ? (~sum + 1'b1) : sum;
    end
  end

endmodule

// File: tb/tb_mult_iter_nxw.sv
// Scoreboard bench for mult_iter_nxw: one instance with EARLY_EXIT=0, one with EARLY_EXIT=1.
module tb_mult_iter_nxw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        in_valid = 0, a_signed = 0, b_signed = 0, flush = 0, out_ready = 1;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] product;

  logic        in_valid_e = 0, a_signed_e = 0, b_signed_e = 0, flush_e = 0, out_ready_e = 1;
  logic [31:0] a_e = '0, b_e = '0;
  logic        in_ready_e, out_valid_e, busy_e;
  logic [63:0] product_e;

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  mult_iter_nxw #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  mult_iter_nxw #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_e), .in_ready(in_ready_e),
    .a(a_e), .b(b_e), .a_signed(a_signed_e), .b_signed(b_signed_e), .flush(flush_e),
    .out_valid(out_valid_e), .out_ready(out_ready_e), .product(product_e), .busy(busy_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Presents one request on a negedge and returns 1ns after the accepting edge.
  task automatic accept_raw(input bit sel, input logic [31:0] av, input logic [31:0] bv,
                            input logic as, input logic bs);
    int n = 0;
    @(negedge clk);
    while (((sel ? in_ready_e : in_ready) == 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 64'(n), 64'(0));
    if (sel) begin a_e = av; b_e = bv; a_signed_e = as; b_signed_e = bs; in_valid_e = 1; end
    else     begin a = av;   b = bv;   a_signed = as;   b_signed = bs;   in_valid = 1;   end
    @(posedge clk);
    #1;
    // Scramble inputs: only the accept edge may sample them.
    if (sel) begin in_valid_e = 0; a_e = ~av; b_e = ~bv; a_signed_e = ~as; b_signed_e = ~bs; end
    else     begin in_valid = 0;   a = ~av;   b = ~bv;   a_signed = ~as;   b_signed = ~bs;   end
  endtask

  task automatic req(input bit sel, input logic [31:0] av, input logic [31:0] bv,
                     input logic as, input logic bs, input logic [63:0] exp, input int lat);
    exp_t e;
    accept_raw(sel, av, bv, as, bs);
    e = '{prod: exp, lat: lat, acc: cyc};
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  // Waits for out_valid; while still calculating the block must look busy and refuse input.
  task automatic wait_done(input bit sel);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((sel ? out_valid_e : out_valid) == 1'b1) break;
      check(sel ? "calc_in_ready_e" : "calc_in_ready", 64'(sel ? in_ready_e : in_ready), 64'(0));
      check(sel ? "calc_busy_e" : "calc_busy", 64'(sel ? busy_e : busy), 64'(1));
      n++;
      if (n > 40) begin
        check("done_timeout", 64'(n), 64'(0));
        break;
      end
    end
  endtask

  initial begin : mon0
    logic        ov_prev = 0;
    logic [63:0] held = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (out_valid && !ov_prev) begin
        if (q0.size() == 0) check("unexpected_out", product, 64'hx);
        else begin
          e = q0.pop_front();
          check("product", product, e.prod);
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end else if (out_valid && ov_prev) begin
        check("hold_product", product, held);
        check("done_in_ready", 64'(in_ready), 64'(0));
      end
      ov_prev = out_valid;
      held    = product;
    end
  end

  initial begin : mon1
    logic        ov_prev = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (out_valid_e && !ov_prev) begin
        if (q1.size() == 0) check("unexpected_out_e", product_e, 64'hx);
        else begin
          e = q1.pop_front();
          check("product_e", product_e, e.prod);
          check("latency_e", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
      ov_prev = out_valid_e;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    #1 rst_n = 0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_product", product, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Full-latency path, mixed signedness.
    req(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE00000001, 4); wait_done(0);
    req(0, 32'h80000000, 32'h80000000, 1, 1, 64'h4000000000000000, 4); wait_done(0);
    req(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFF00000001, 4); wait_done(0);
    req(0, 32'h00000007, 32'hFFFFFFFD, 1, 1, 64'hFFFFFFFFFFFFFFEB, 4); wait_done(0);
    req(0, 32'h12345678, 32'h00000003, 0, 0, 64'h00000000369D0368, 4); wait_done(0);

    // Early exit: latency follows the highest non-zero chunk of |b|.
    req(1, 32'h12345678, 32'h00000003, 0, 0, 64'h00000000369D0368, 1); wait_done(1);
    req(1, 32'hFFFFFFFB, 32'h00000000, 1, 1, 64'h0000000000000000, 1); wait_done(1);
    req(1, 32'hFFFFFFFF, 32'h00000100, 1, 1, 64'hFFFFFFFFFFFFFF00, 2); wait_done(1);
    req(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE00000001, 4); wait_done(1);

    // Backpressure in DONE with an ignored in_valid pulse.
    out_ready = 0;
    req(0, 32'h00010001, 32'h00000010, 0, 0, 64'h0000000000100010, 4);
    wait_done(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      if (i == 2) begin a = 32'h55; b = 32'h66; end
    end
    in_valid  = 0;
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 64'(out_valid), 64'(0));
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    check("bp_release_busy", 64'(busy), 64'(0));

    // Flush in the second CALC cycle.
    accept_raw(0, 32'h5, 32'h9, 0, 0);
    @(negedge clk);
    @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_in_ready", 64'(in_ready), 64'(1));
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_product_kept", product, 64'h0000000000100010);
    // Flush in IDLE blocks the accept on that edge.
    @(negedge clk);
    in_valid = 1; a = 32'h9; b = 32'h9;
    @(posedge clk); #1;
    check("flush_idle_busy", 64'(busy), 64'(0));
    check("flush_idle_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 0;
    flush    = 0;
    req(0, 32'h2, 32'h3, 0, 0, 64'h6, 4); wait_done(0);

    // Asynchronous reset mid-CALC.
    accept_raw(0, 32'h1234, 32'h5678, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_product", product, 64'h0);
    @(negedge clk);
    rst_n = 1;
    req(0, 32'hFFFFFFFE, 32'h00000003, 1, 0, 64'hFFFFFFFFFFFFFFFA, 4); wait_done(0);

    repeat (4) @(negedge clk);
    check("q0_drained", 64'(q0.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
